// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared constants, widths, types and helpers for the age-ordered slot allocator
package sched_pkg;

  localparam int SCHED_SLOTS   = 8;
  localparam int SCHED_GROUP   = 4;
  localparam int SCHED_MAX_NEW = 3;

  // Width of ready_count / used_count, and of one arrival index
  localparam int CW = $clog2(SCHED_MAX_NEW + 1);
  localparam int IW = (SCHED_MAX_NEW > 1) ? $clog2(SCHED_MAX_NEW) : 1;

  typedef logic age_mat_t [SCHED_SLOTS][SCHED_SLOTS];

  // Population count of v, clipped at cap
  function automatic int popcount_sat(input logic [63:0] v, input int cap);
    int n;
    n = 0;
    for (int b = 0; b < 64; b++) begin
      n = n + int'(v[b]);
    end
    return (n > cap) ? cap : n;
  endfunction

endpackage

// File: rtl/sched_age_matrix.sv
// rtl/sched_age_matrix.sv - upper-triangle age storage, new-slot update, occupancy and oldest-slot detect
module sched_age_matrix
  import sched_pkg::*;
#(
  parameter int SLOTS = SCHED_SLOTS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [SLOTS-1:0]              remain_i,
  input  logic [SLOTS-1:0]              new_mask_i,
  output logic [SLOTS-1:0][SLOTS-1:0]   is_after_o,
  output logic [SLOTS-1:0][SLOTS-1:0]   is_after_next_o,
  output logic [SLOTS-1:0]              occupied_o,
  output logic [SLOTS-1:0]              oldest_onehot_o
);

  // One bit per unordered pair (i<j): 1 means slot i is younger than slot j
  localparam int NPAIR = SLOTS * (SLOTS - 1) / 2;

  logic [NPAIR-1:0] upper_q, upper_d;
  logic [SLOTS-1:0] occ_q, occ_d;
  logic [SLOTS-1:0] oldest;

  for (genvar i = 0; i < SLOTS; i++) begin : g_row
    for (genvar j = 0; j < SLOTS; j++) begin : g_col
      if (j > i) begin : g_pair
        localparam int P = i * SLOTS - (i * (i + 1)) / 2 + (j - i - 1);
        // Ascending processing: a write to j clears column j last, so j wins over i
        assign upper_d[P]            = new_mask_i[j] ? 1'b0 : (new_mask_i[i] ? 1'b1 : upper_q[P]);
        assign is_after_o[i][j]      = upper_q[P];
        assign is_after_o[j][i]      = ~upper_q[P];
        assign is_after_next_o[i][j] = upper_d[P];
        assign is_after_next_o[j][i] = ~upper_d[P];
      end else if (j == i) begin : g_diag
        assign is_after_o[i][i]      = 1'b0;
        assign is_after_next_o[i][i] = 1'b0;
      end
    end
  end

  assign occ_d = remain_i | new_mask_i;

  // Age triangle and occupancy registers; reset order is "higher index is younger"
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upper_q <= '0;
      occ_q   <= '0;
    end else begin
      upper_q <= upper_d;
      occ_q   <= occ_d;
    end
  end

  // Oldest: occupied and not younger than any other occupied slot
  always_comb begin
    oldest = '0;
    for (int i = 0; i < SLOTS; i++) begin
      oldest[i] = occ_q[i];
      for (int j = 0; j < SLOTS; j++) begin
        if (j != i && occ_q[j] && is_after_o[i][j]) begin
          oldest[i] = 1'b0;
        end
      end
    end
  end

  assign occupied_o      = occ_q;
  assign oldest_onehot_o = oldest;

endmodule

// File: rtl/sched_age_alloc.sv
// rtl/sched_age_alloc.sv - window slot allocator with age matrix; SCHED_AGE_ALLOC_STALL_CNT_EN adds stall_cycles
module sched_age_alloc
  import sched_pkg::*;
#(
  parameter  int SLOTS   = SCHED_SLOTS,
  parameter  int GROUP   = SCHED_GROUP,
  parameter  int MAX_NEW = SCHED_MAX_NEW,
  localparam int CW_L    = $clog2(MAX_NEW + 1),
  localparam int IW_L    = (MAX_NEW > 1) ? $clog2(MAX_NEW) : 1
) (
  input  logic                            main_clk,
  input  logic                            main_rst,
  input  logic [SLOTS-1:0]                possible_remain_valid,
  input  logic                            jump_triggering_now,
  input  logic [CW_L-1:0]                 ready_count,
  output logic [CW_L-1:0]                 used_count,
  output logic [SLOTS-1:0]                new_mask,
  output logic [SLOTS-1:0][IW_L-1:0]      set_index,
  output logic [SLOTS-1:0][SLOTS-1:0]     is_after,
  output logic [SLOTS-1:0][SLOTS-1:0]     is_after_next,
  output logic [SLOTS-1:0]                occupied,
  output logic [SLOTS-1:0]                oldest_onehot
`ifdef SCHED_AGE_ALLOC_STALL_CNT_EN
  , output logic [31:0]                   stall_cycles
`endif
);

  localparam int NGROUP = SLOTS / GROUP;

  logic [SLOTS-1:0] free;
  assign free = ~possible_remain_valid;

  // Accept count, then group-by-group placement into lowest free slots
  always_comb begin
    int avail;
    int want;
    int take;
    int rem;
    int placed;
    int g_free;
    int g_take;
    int loc;
    used_count = '0;
    new_mask   = '0;
    set_index  = '0;
    avail = popcount_sat(64'(free), MAX_NEW);
    want  = int'(ready_count);
    if (want > MAX_NEW) want = MAX_NEW;
    take  = (want < avail) ? want : avail;
    if (main_rst || jump_triggering_now) take = 0;
    used_count = CW_L'(take);
    rem    = take;
    placed = 0;
    for (int g = 0; g < NGROUP; g++) begin
      g_free = popcount_sat(64'(free[g*GROUP +: GROUP]), GROUP);
      g_take = (rem < g_free) ? rem : g_free;
      loc    = 0;
      for (int s = 0; s < GROUP; s++) begin
        if (free[g*GROUP+s] && loc < g_take) begin
          new_mask[g*GROUP+s]  = 1'b1;
          set_index[g*GROUP+s] = IW_L'(placed + loc);
          loc = loc + 1;
        end
      end
      placed = placed + g_take;
      rem    = rem - g_take;
    end
  end

  sched_age_matrix #(
    .SLOTS (SLOTS)
  ) u_matrix (
    .clk_i           (main_clk),
    .rst_i           (main_rst),
    .remain_i        (possible_remain_valid),
    .new_mask_i      (new_mask),
    .is_after_o      (is_after),
    .is_after_next_o (is_after_next),
    .occupied_o      (occupied),
    .oldest_onehot_o (oldest_onehot)
  );

`ifdef SCHED_AGE_ALLOC_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Next stall count: bump when offered work was not fully accepted, hold at all-ones
  always_comb begin
    stall_d = stall_q;
    if (ready_count != '0 && used_count < ready_count && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sched_age_alloc.sv
// tb/tb_sched_age_alloc.sv - scoreboard bench for sched_age_alloc with directed allocation vectors
module tb_sched_age_alloc;
  import sched_pkg::*;

  localparam int S = SCHED_SLOTS;

  logic                     main_clk = 1'b0;
  logic                     main_rst;
  logic [S-1:0]             possible_remain_valid;
  logic                     jump_triggering_now;
  logic [CW-1:0]            ready_count;
  logic [CW-1:0]            used_count;
  logic [S-1:0]             new_mask;
  logic [S-1:0][IW-1:0]     set_index;
  logic [S-1:0][S-1:0]      is_after;
  logic [S-1:0][S-1:0]      is_after_next;
  logic [S-1:0]             occupied;
  logic [S-1:0]             oldest_onehot;
`ifdef SCHED_AGE_ALLOC_STALL_CNT_EN
  logic [31:0]              stall_cycles;
`endif

  sched_age_alloc dut (
    .main_clk              (main_clk),
    .main_rst              (main_rst),
    .possible_remain_valid (possible_remain_valid),
    .jump_triggering_now   (jump_triggering_now),
    .ready_count           (ready_count),
    .used_count            (used_count),
    .new_mask              (new_mask),
    .set_index             (set_index),
    .is_after              (is_after),
    .is_after_next         (is_after_next),
    .occupied              (occupied),
    .oldest_onehot         (oldest_onehot)
`ifdef SCHED_AGE_ALLOC_STALL_CNT_EN
    , .stall_cycles        (stall_cycles)
`endif
  );

  always #5 main_clk = ~main_clk;

  typedef struct {
    string           name;
    logic [CW-1:0]   used;
    logic [S-1:0]    mask;
    logic [S*IW-1:0] si;
    logic [S-1:0]    occ;
    logic [S-1:0]    oldest;
    logic [S*S-1:0]  mat;
    logic [S*S-1:0]  mat_n;
    int              stall;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference age model: each slot carries an arrival stamp, larger is younger
  int           ts[S];
  int           ts_n[S];
  logic [S-1:0] m_occ;
  int           m_cnt;
  int           m_stall;

  function automatic logic [S*S-1:0] mat_of(input int t[S]);
    logic [S*S-1:0] m;
    m = '0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        m[i*S+j] = (i != j) && (t[i] > t[j]);
    return m;
  endfunction

  function automatic logic [S-1:0] oldest_of(input int t[S], input logic [S-1:0] occ);
    logic [S-1:0] o;
    int best;
    o = '0;
    best = -1;
    for (int i = 0; i < S; i++)
      if (occ[i] && (best < 0 || t[i] < t[best])) best = i;
    if (best >= 0) o[best] = 1'b1;
    return o;
  endfunction

  task automatic chk(input string step, input string what, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", step, what, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic [S-1:0] p, input logic j,
                      input int ready, input int eu, input logic [S-1:0] em, input logic [S*IW-1:0] esi);
    exp_t e;
    main_rst              = r;
    possible_remain_valid = p;
    jump_triggering_now   = j;
    ready_count           = CW'(ready);
    for (int k = 0; k < S; k++)
      ts_n[k] = em[k] ? (m_cnt + int'(esi[k*IW +: IW])) : ts[k];
    e.name   = nm;
    e.used   = CW'(eu);
    e.mask   = em;
    e.si     = esi;
    e.occ    = m_occ;
    e.oldest = oldest_of(ts, m_occ);
    e.mat    = mat_of(ts);
    e.mat_n  = mat_of(ts_n);
    e.stall  = m_stall;
    q.push_back(e);
    if (r) begin
      for (int k = 0; k < S; k++) ts[k] = k;
      m_occ   = '0;
      m_cnt   = S;
      m_stall = 0;
    end else begin
      for (int k = 0; k < S; k++) ts[k] = ts_n[k];
      m_cnt = m_cnt + eu;
      m_occ = p | em;
      if (ready > 0 && eu < ready) m_stall++;
    end
    @(posedge main_clk);
    #1;
  endtask

  // Monitor: every falling edge with a pending expectation is compared
  initial begin
    exp_t e;
    forever begin
      @(negedge main_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "used_count",    64'(used_count),    64'(e.used));
        chk(e.name, "new_mask",      64'(new_mask),      64'(e.mask));
        chk(e.name, "set_index",     64'(set_index),     64'(e.si));
        chk(e.name, "occupied",      64'(occupied),      64'(e.occ));
        chk(e.name, "oldest_onehot", 64'(oldest_onehot), 64'(e.oldest));
        chk(e.name, "is_after",      64'(is_after),      64'(e.mat));
        chk(e.name, "is_after_next", 64'(is_after_next), 64'(e.mat_n));
`ifdef SCHED_AGE_ALLOC_STALL_CNT_EN
        chk(e.name, "stall_cycles",  64'(stall_cycles),  64'(e.stall));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < S; k++) ts[k] = k;
    m_occ   = '0;
    m_cnt   = S;
    m_stall = 0;
    main_rst              = 1'b1;
    possible_remain_valid = '0;
    jump_triggering_now   = 1'b0;
    ready_count           = '0;
    @(posedge main_clk);
    #1;
    //    name          rst  remain  jmp rdy used mask   set_index
    step("rst_a",       1,   8'h00,  0,  3,  0,   8'h00, 16'h0000);
    step("rst_b",       1,   8'h00,  0,  3,  0,   8'h00, 16'h0000);
    step("alloc3",      0,   8'h00,  0,  3,  3,   8'h07, 16'h0024);
    step("grp_part",    0,   8'hF3,  0,  3,  2,   8'h0C, 16'h0040);
    step("chain",       0,   8'h7E,  0,  2,  2,   8'h81, 16'h4000);
    step("jump",        0,   8'h00,  1,  3,  0,   8'h00, 16'h0000);
    step("full",        0,   8'hFF,  0,  3,  0,   8'h00, 16'h0000);
    step("drain",       0,   8'h00,  0,  0,  0,   8'h00, 16'h0000);
    step("refill",      0,   8'h00,  0,  3,  3,   8'h07, 16'h0024);
    step("retire0",     0,   8'h06,  0,  0,  0,   8'h00, 16'h0000);
    step("realloc0",    0,   8'h06,  0,  1,  1,   8'h01, 16'h0000);
    step("over_free",   0,   8'hFE,  0,  3,  1,   8'h01, 16'h0000);
    step("hi_slot",     0,   8'h7F,  0,  2,  1,   8'h80, 16'h0000);
    step("grp1_only",   0,   8'h0F,  0,  3,  3,   8'h70, 16'h2400);
    step("mid_rst",     1,   8'h00,  0,  3,  0,   8'h00, 16'h0000);
    step("post_rst",    0,   8'h00,  0,  1,  1,   8'h01, 16'h0000);
    for (int n = 0; n < 5; n++)
      step("stall",     0,   8'hFF,  0,  2,  0,   8'h00, 16'h0000);
    step("stall_chk",   1,   8'hFF,  0,  2,  0,   8'h00, 16'h0000);
    step("stall_clr",   0,   8'hFF,  0,  0,  0,   8'h00, 16'h0000);
    chk("end", "queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sched_age_alloc.md
Name: sched_age_alloc

Overview:
- Parametrised slot allocator and age tracker for the out-of-order instruction window.
- Each cycle it takes up to MAX_NEW ready instructions from decode and assigns them to the lowest-numbered free slots.
- Per allocated slot it reports the arrival index within the group, and it maintains a registered pairwise age matrix.
- Adds over the previous generation: slot count and issue width as parameters, synchronous reset, occupancy tracking, and oldest-slot detection.

Parameters:
- SLOTS, 8, number of window slots; must be a multiple of GROUP.
- GROUP, 4, slots per allocation group; free counting and slot assignment are done per group, then chained across groups.
- MAX_NEW, 3, maximum instructions accepted per cycle; range 1..GROUP.

Ports:
- main_clk  in  1  clock
- main_rst  in  1  synchronous reset, active-high
- possible_remain_valid  in  SLOTS  slot stays occupied next cycle; a 0 bit means the slot is free for allocation
- jump_triggering_now  in  1  suppresses all allocation this cycle
- ready_count  in  CW  instructions offered this cycle; CW=$clog2(MAX_NEW+1)
- used_count  out  CW  instructions accepted this cycle
- new_mask  out  SLOTS  slots written this cycle
- set_index  out  SLOTS x IW  arrival index of the instruction written into each slot; IW=max(1,$clog2(MAX_NEW))
- is_after  out  SLOTS x SLOTS  current age matrix; [i][j]=1 means slot i is younger than slot j
- is_after_next  out  SLOTS x SLOTS  matrix to be registered this edge
- occupied  out  SLOTS  registered occupancy
- oldest_onehot  out  SLOTS  oldest occupied slot; all zero if the window is empty

Behaviour:
- Reset values:
  - Stored age matrix: [i][j]=1 iff i>j.
  - occupied=0.
  - While main_rst is high: new_mask=0, used_count=0, and every set_index=0.
- Allocation is combinational, zero latency:
  - free = ~possible_remain_valid.
  - used_count = min(ready_count, popcount(free) saturated at MAX_NEW, MAX_NEW).
  - used_count is forced to 0 when jump_triggering_now=1 or main_rst=1.
- Slot assignment:
  - Groups are filled in order g=0,1,...
  - Group g receives min(remaining, free count in g) instructions, placed into its lowest-index free slots.
  - set_index = number of instructions placed in lower slots this cycle, counting across groups.
  - set_index of a slot not in new_mask is don't-care but must be driven to 0.
- Age matrix storage:
  - Only the upper triangle j>i is stored.
  - Lower triangle is derived: is_after[i][j] = !stored[j][i] for i>j.
  - Diagonal is always 0.
- Update for each slot k in new_mask:
  - Row k is set to all 1s, column k is cleared, and the diagonal is held at 0.
  - Slots are processed in ascending index, so same-cycle arrivals are ordered by slot index. This is consistent with set_index.
- is_after_next is the antisymmetric re-derivation of the updated matrix; it is registered on every posedge main_clk.
- Occupancy: occupied_next = possible_remain_valid | new_mask. possible_remain_valid bits for unoccupied slots are legal and are treated as occupied next cycle.
- oldest_onehot:
  - Bit i is set iff occupied[i] and, for every occupied j≠i, is_after[i][j]=0.
  - It is combinational from registered state only, with no dependence on this cycle's inputs.
- Boundary cases:
  - All slots remain valid: used_count=0.
  - ready_count > free slots: accept only as many as there are free slots; ready_count is not consumed beyond used_count.
  - ready_count > MAX_NEW: clipped to MAX_NEW.
  - Jump together with free slots: no allocation; the matrix evolves only through the re-derivation.
  - Reset asserted mid-operation: takes effect on the next edge and overrides any allocation in that cycle.

Optional Feature:
- Macro: SCHED_AGE_ALLOC_STALL_CNT_EN.
- When defined: adds output stall_cycles (32 bits).
  - It increments, saturating, on every cycle where ready_count>0, main_rst=0 and used_count<ready_count.
  - It is cleared by main_rst.
- When undefined: the port and counter are absent and there is no other change.

Decomposition:
- Package sched_pkg holds:
  - Constants SCHED_SLOTS, SCHED_GROUP and SCHED_MAX_NEW.
  - The derived widths CW and IW.
  - Typedef age_mat_t, an unpacked SLOTS x SLOTS logic array.
  - Function popcount_sat.
- Sub-module sched_age_matrix holds the triangle storage, the new_mask update, the derivation of is_after / is_after_next, and the oldest detection.
- The top level keeps group counting and slot assignment.

Test Plan:
- Reset then ready_count=3 with all slots free:
  - new_mask=8'h07, set_index[0..2]=0,1,2, used_count=3.
  - Next cycle: is_after[2][0]=1, is_after[0][2]=0, oldest_onehot=8'h01.
- possible_remain_valid=8'hF3 (free slots 2,3) with ready_count=3: used_count=2, new_mask=8'h0C, set_index[2]=0, set_index[3]=1.
- possible_remain_valid=8'h7E (free slots 0 and 7) with ready_count=2: new_mask=8'h81, set_index[0]=0, set_index[7]=1, group chaining confirmed.
- jump_triggering_now=1 with ready_count=3 and all slots free: used_count=0, new_mask=0, and the matrix unchanged after the edge.
- Slot 0 retires and is then reallocated: slot 0 becomes youngest, is_after[0][j]=1 for every other occupied j, and oldest_onehot moves to the oldest survivor.
- With the macro defined: 5 cycles of ready_count=2 and no free slots give stall_cycles=5; main_rst then gives 0.
